// File: rtl/cva6_wbuf_pkg.sv
// Shared types for the write-through store buffer: entry state, entry record and word offset.
package cva6_wbuf_pkg;

  localparam int unsigned WBUF_ADDR_W  = 32;
  localparam int unsigned WBUF_DATA_W  = 32;
  localparam int unsigned WBUF_BE_W    = WBUF_DATA_W / 8;
  localparam int unsigned WBUF_OFF_W   = $clog2(WBUF_BE_W);
  localparam int unsigned WBUF_WADDR_W = WBUF_ADDR_W - WBUF_OFF_W;

  typedef enum logic [1:0] {
    WBUF_FREE,
    WBUF_PEND,
    WBUF_INFL
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_WADDR_W-1:0] waddr;
    logic [WBUF_DATA_W-1:0]  data;
    logic [WBUF_BE_W-1:0]    be;
    wbuf_state_e             state;
  } wbuf_entry_t;

  localparam wbuf_entry_t WBUF_ENTRY_RST = '{waddr: '0, data: '0, be: '0, state: WBUF_FREE};

endpackage

// File: rtl/cva6_wbuf_match.sv
// Parallel word-address comparator across all buffer entries; returns one hit bit per entry.
module cva6_wbuf_match #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 30
) (
  input  logic [DEPTH-1:0][AW-1:0] addrs_i,
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [AW-1:0]            addr_i,
  output logic [DEPTH-1:0]         hit_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_o[i] = valid_i[i] && (addrs_i[i] == addr_i);
    end
  end

endmodule

// File: rtl/cva6_wt_store_wbuf.sv
// In-order store write buffer in front of the write-through dcache port.
// Optional store merging into the youngest pending entry: define CVA6_WBUF_COALESCE_EN.
module cva6_wt_store_wbuf
  import cva6_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = WBUF_ADDR_W,
  parameter int unsigned DATA_W  = WBUF_DATA_W,
  parameter int unsigned MAX_OUT = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic                empty_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = WBUF_OFF_W;
  localparam int unsigned WA_W  = ADDR_W - OFF_W;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = $clog2(MAX_OUT + 1);

  wbuf_entry_t entries_q [DEPTH];
  wbuf_entry_t entries_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, iss_ptr_q, iss_ptr_d, ack_ptr_q, ack_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;

  logic do_accept, do_alloc, do_merge, do_gnt, do_ack;
  logic [DEPTH-1:0][WA_W-1:0] waddrs;
  logic [DEPTH-1:0]           busy_vec, ld_hits;
  logic                       unused_low_bits;

  // PEND count is cnt - out_cnt; keeping both counters avoids pointer-equality ambiguity.
  assign st_ready_o = (cnt_q != CW'(DEPTH));
  assign mem_req_o  = (cnt_q != CW'(out_cnt_q)) && (out_cnt_q < OW'(MAX_OUT));
  assign mem_addr_o = {entries_q[iss_ptr_q].waddr, {OFF_W{1'b0}}};
  assign mem_data_o = entries_q[iss_ptr_q].data;
  assign mem_be_o   = entries_q[iss_ptr_q].be;
  assign empty_o    = (cnt_q == '0);
  assign ld_hit_o   = |ld_hits;

  assign do_accept = st_valid_i && st_ready_o;
  assign do_gnt    = mem_req_o && mem_gnt_i;
  assign do_ack    = mem_ack_i && (out_cnt_q != '0);
  assign do_alloc  = do_accept && !do_merge;

  assign unused_low_bits = ^{st_addr_i[OFF_W-1:0], ld_addr_i[OFF_W-1:0]};

  always_comb begin
    waddrs   = '0;
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      waddrs[i]   = entries_q[i].waddr;
      busy_vec[i] = (entries_q[i].state != WBUF_FREE);
    end
  end

  cva6_wbuf_match #(.DEPTH(DEPTH), .AW(WA_W)) u_ld_match (
    .addrs_i (waddrs),
    .valid_i (busy_vec),
    .addr_i  (ld_addr_i[ADDR_W-1:OFF_W]),
    .hit_o   (ld_hits)
  );

`ifdef CVA6_WBUF_COALESCE_EN
  logic [PW-1:0]    tail_ptr;
  logic [DEPTH-1:0] pend_vec, st_hits;

  assign tail_ptr = wr_ptr_q - PW'(1);

  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < DEPTH; i++) pend_vec[i] = (entries_q[i].state == WBUF_PEND);
  end

  cva6_wbuf_match #(.DEPTH(DEPTH), .AW(WA_W)) u_st_match (
    .addrs_i (waddrs),
    .valid_i (pend_vec),
    .addr_i  (st_addr_i[ADDR_W-1:OFF_W]),
    .hit_o   (st_hits)
  );

  // The entry on the request port must stay stable until granted, so it never absorbs a merge.
  assign do_merge = do_accept && st_hits[tail_ptr] && !(mem_req_o && (iss_ptr_q == tail_ptr));
`else
  assign do_merge = 1'b0;
`endif

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    iss_ptr_d = iss_ptr_q;
    ack_ptr_d = ack_ptr_q;
    if (do_ack) begin
      entries_d[ack_ptr_q].state = WBUF_FREE;
      ack_ptr_d = ack_ptr_q + PW'(1);
    end
    if (do_gnt) begin
      entries_d[iss_ptr_q].state = WBUF_INFL;
      iss_ptr_d = iss_ptr_q + PW'(1);
    end
    if (do_alloc) begin
      entries_d[wr_ptr_q] = '{waddr: st_addr_i[ADDR_W-1:OFF_W], data: st_data_i,
                              be: st_be_i, state: WBUF_PEND};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
`ifdef CVA6_WBUF_COALESCE_EN
    if (do_merge) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be_i[b]) entries_d[tail_ptr].data[8*b +: 8] = st_data_i[8*b +: 8];
      end
      entries_d[tail_ptr].be = entries_q[tail_ptr].be | st_be_i;
    end
`endif
    cnt_d     = cnt_q + CW'(do_alloc) - CW'(do_ack);
    out_cnt_d = out_cnt_q + OW'(do_gnt) - OW'(do_ack);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: entry storage is reset (not just state) because mem_* outputs must read zero out of reset.
      entries_q <= '{default: WBUF_ENTRY_RST};
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      ack_ptr_q <= '0;
      cnt_q     <= '0;
      out_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      iss_ptr_q <= iss_ptr_d;
      ack_ptr_q <= ack_ptr_d;
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Warning severity: late acks after a mid-operation reset are expected and harmless.
  spurious_ack_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(mem_ack_i && (out_cnt_q == '0)))
    else $warning("cva6_wt_store_wbuf: ack with no store in flight ignored");

endmodule

// File: tb/tb_cva6_wt_store_wbuf.sv
// Directed bench for cva6_wt_store_wbuf: vector table for the basic flow plus corner sequences.
module tb_cva6_wt_store_wbuf;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        st_valid_i, st_ready_o;
  logic [31:0] st_addr_i, st_data_i;
  logic [3:0]  st_be_i;
  logic        mem_req_o, mem_gnt_i, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_be_o;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o, empty_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CVA6_WBUF_COALESCE_EN
  localparam int          EXP_GRANTS = 2;
  localparam logic [3:0]  EXP_BE2    = 4'h6;
  localparam logic [31:0] EXP_DATA2  = 32'h0033_2200;
`else
  localparam int          EXP_GRANTS = 3;
  localparam logic [3:0]  EXP_BE2    = 4'h2;
  localparam logic [31:0] EXP_DATA2  = 32'h0000_2200;
`endif

  always #5 clk_i = ~clk_i;

  cva6_wt_store_wbuf dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .st_valid_i (st_valid_i),
    .st_ready_o (st_ready_o),
    .st_addr_i  (st_addr_i),
    .st_data_i  (st_data_i),
    .st_be_i    (st_be_i),
    .mem_req_o  (mem_req_o),
    .mem_gnt_i  (mem_gnt_i),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_be_o   (mem_be_o),
    .mem_ack_i  (mem_ack_i),
    .ld_addr_i  (ld_addr_i),
    .ld_hit_o   (ld_hit_o),
    .empty_o    (empty_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        gnt;
    logic        ack;
    logic [31:0] ld;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_hit;
    logic        e_empty;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    st_valid_i = 1'b0;
    st_addr_i  = '0;
    st_data_i  = '0;
    st_be_i    = '0;
    mem_gnt_i  = 1'b0;
    mem_ack_i  = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = d;
    st_be_i    = be;
  endtask

  task automatic do_reset();
    idle();
    ld_addr_i = '0;
    rst_ni    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 32'(st_ready_o), 32'd1);
    check({tag, " req"},   32'(mem_req_o),  32'd0);
    check({tag, " hit"},   32'(ld_hit_o),   32'd0);
    check({tag, " empty"}, 32'(empty_o),    32'd1);
    check({tag, " addr"},  mem_addr_o,      32'd0);
    check({tag, " data"},  mem_data_o,      32'd0);
    check({tag, " be"},    32'(mem_be_o),   32'd0);
  endtask

  initial begin
    int grants;
    int accepted;
    logic [31:0] g2_data;
    logic [3:0]  g2_be;

    // Single store: accepted cycle 1, req cycle 2, grant cycle 3, ack cycle 5, empty cycle 6.
    vecs[0] = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h8000_0004,
                1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h8000_0004,
                1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8000_0004,
                1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h8000_0004,
                1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h8000_0004,
                1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h8000_0004,
                1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1};

    do_reset();
    #1;
    check_reset_outputs("reset");

    for (int i = 0; i < 6; i++) begin
      st_valid_i = vecs[i].v;
      st_addr_i  = vecs[i].a;
      st_data_i  = vecs[i].d;
      st_be_i    = vecs[i].be;
      mem_gnt_i  = vecs[i].gnt;
      mem_ack_i  = vecs[i].ack;
      ld_addr_i  = vecs[i].ld;
      #1;
      check($sformatf("vec%0d ready", i), 32'(st_ready_o), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d req", i),   32'(mem_req_o),  32'(vecs[i].e_req));
      check($sformatf("vec%0d addr", i),  mem_addr_o,      vecs[i].e_addr);
      check($sformatf("vec%0d data", i),  mem_data_o,      vecs[i].e_data);
      check($sformatf("vec%0d be", i),    32'(mem_be_o),   32'(vecs[i].e_be));
      check($sformatf("vec%0d hit", i),   32'(ld_hit_o),   32'(vecs[i].e_hit));
      check($sformatf("vec%0d empty", i), 32'(empty_o),    32'(vecs[i].e_empty));
      cyc();
    end

    // Full buffer: 9 offers with no grant, 8 accepted; grant then ack re-opens one cycle later.
    do_reset();
    accepted = 0;
    for (int i = 0; i < 9; i++) begin
      store(32'h100 + 32'(4 * i), 32'(i), 4'hF);
      #1;
      check($sformatf("full offer%0d ready", i), 32'(st_ready_o), (i < 8) ? 32'd1 : 32'd0);
      if (st_ready_o) accepted++;
      cyc();
    end
    idle();
    check("full accepted", 32'(accepted), 32'd8);
    mem_gnt_i = 1'b1;
    #1;
    check("full first req", 32'(mem_req_o), 32'd1);
    check("full first addr", mem_addr_o, 32'h100);
    cyc();
    mem_gnt_i = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    check("full next addr", mem_addr_o, 32'h104);
    check("full ready in ack cycle", 32'(st_ready_o), 32'd0);
    cyc();
    mem_ack_i = 1'b0;
    #1;
    check("full ready after ack", 32'(st_ready_o), 32'd1);

    // In-flight limit: grant every cycle, 7 grants then stall; one ack lets the 8th through.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store(32'h100 + 32'(4 * i), 32'(i), 4'hF);
      cyc();
    end
    idle();
    grants = 0;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (mem_req_o) begin
        check($sformatf("maxout grant%0d addr", grants), mem_addr_o, 32'h100 + 32'(4 * grants));
        grants++;
      end
      cyc();
    end
    check("maxout grants", 32'(grants), 32'd7);
    check("maxout req stalled", 32'(mem_req_o), 32'd0);
    mem_ack_i = 1'b1;
    #1;
    check("maxout req in ack cycle", 32'(mem_req_o), 32'd0);
    cyc();
    mem_ack_i = 1'b0;
    #1;
    check("maxout req after ack", 32'(mem_req_o), 32'd1);
    check("maxout 8th addr", mem_addr_o, 32'h11C);
    cyc();
    #1;
    check("maxout req drained", 32'(mem_req_o), 32'd0);

    // Same-word stores: the presented entry never merges, the next one may.
    do_reset();
    store(32'h1000, 32'h0000_0011, 4'h1);
    cyc();
    store(32'h1000, 32'h0000_2200, 4'h2);
    cyc();
    store(32'h1000, 32'h0033_0000, 4'h4);
    cyc();
    idle();
    grants  = 0;
    g2_data = '0;
    g2_be   = '0;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_req_o) begin
        grants++;
        if (grants == 1) begin
          check("coal grant1 data", mem_data_o, 32'h11);
          check("coal grant1 be", 32'(mem_be_o), 32'h1);
        end
        if (grants == 2) begin
          g2_data = mem_data_o;
          g2_be   = mem_be_o;
        end
      end
      cyc();
    end
    mem_gnt_i = 1'b0;
    check("coal grants", 32'(grants), 32'(EXP_GRANTS));
    check("coal grant2 data", g2_data, EXP_DATA2);
    check("coal grant2 be", 32'(g2_be), 32'(EXP_BE2));
    mem_ack_i = 1'b1;
    repeat (EXP_GRANTS) cyc();
    mem_ack_i = 1'b0;
    #1;
    check("coal empty after acks", 32'(empty_o), 32'd1);

    // Load hit is word-granular; async reset with two stores in flight; late ack is ignored.
    do_reset();
    store(32'h2008, 32'hAB, 4'hF);
    cyc();
    idle();
    ld_addr_i = 32'h200B;
    #1;
    check("ld hit same word", 32'(ld_hit_o), 32'd1);
    ld_addr_i = 32'h200C;
    #1;
    check("ld hit next word", 32'(ld_hit_o), 32'd0);
    store(32'h200C, 32'hCD, 4'hF);
    mem_gnt_i = 1'b1;
    cyc();
    st_valid_i = 1'b0;
    cyc();
    mem_gnt_i = 1'b0;
    #1;
    check("ld two infl req", 32'(mem_req_o), 32'd0);
    check("ld two infl empty", 32'(empty_o), 32'd0);
    check("ld infl hit", 32'(ld_hit_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async reset");
    cyc();
    rst_ni = 1'b1;
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    #1;
    check("late ack empty", 32'(empty_o), 32'd1);
    check("late ack req", 32'(mem_req_o), 32'd0);
    store(32'h3000, 32'h77, 4'hF);
    cyc();
    idle();
    #1;
    check("post reset req", 32'(mem_req_o), 32'd1);
    check("post reset addr", mem_addr_o, 32'h3000);
    mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    #1;
    check("post reset empty", 32'(empty_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
